// File: rtl/qbus_pkg.sv
// Shared Q-bus sequencer definitions: command encodings, FSM state codes
// and the registered bus-output bundle.
package qbus_pkg;

  typedef enum logic [1:0] {
    QB_RD  = 2'b00,
    QB_WR  = 2'b01,
    QB_WRB = 2'b10,
    QB_IAK = 2'b11
  } qbCmdT;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_ADDR   = 4'd1;
  localparam logic [3:0] ST_ASYNC  = 4'd2;
  localparam logic [3:0] ST_DATA   = 4'd3;
  localparam logic [3:0] ST_STRB   = 4'd4;
  localparam logic [3:0] ST_WRPLY  = 4'd5;
  localparam logic [3:0] ST_SAMPLE = 4'd6;
  localparam logic [3:0] ST_NEG    = 4'd7;
  localparam logic [3:0] ST_WNRPLY = 4'd8;

  typedef struct packed {
    logic        nSync;
    logic        nDin;
    logic        nDout;
    logic        nWtbt;
    logic        nIako;
    logic        oe;
    logic [15:0] nAd;
  } busOutT;

  localparam busOutT BUS_IDLE = '{nSync: 1'b1, nDin: 1'b1, nDout: 1'b1,
                                  nWtbt: 1'b1, nIako: 1'b1, oe: 1'b0,
                                  nAd: 16'hFFFF};

  function automatic logic isWrite(qbCmdT c);
    return (c == QB_WR) || (c == QB_WRB);
  endfunction

endpackage

// File: rtl/qbus_seq_if.sv
// Q-bus pin bundle between the sequencer (master) and the vp_033 pads (slave).
interface qbus_seq_if;
  logic [15:0] PIN_nAD_out;
  logic        PIN_nAD_oe;
  logic [15:0] PIN_nAD_in;
  logic        PIN_nSYNC;
  logic        PIN_nDIN;
  logic        PIN_nDOUT;
  logic        PIN_nWTBT;
  logic        PIN_nIAKO;
  logic        PIN_nRPLY;
  logic        PIN_nVIRQ;

  modport master (
    output PIN_nAD_out, PIN_nAD_oe, PIN_nSYNC, PIN_nDIN, PIN_nDOUT,
           PIN_nWTBT, PIN_nIAKO,
    input  PIN_nAD_in, PIN_nRPLY, PIN_nVIRQ
  );

  modport slave (
    input  PIN_nAD_out, PIN_nAD_oe, PIN_nSYNC, PIN_nDIN, PIN_nDOUT,
           PIN_nWTBT, PIN_nIAKO,
    output PIN_nAD_in, PIN_nRPLY, PIN_nVIRQ
  );
endinterface

// File: rtl/qbus_sync.sv
// Multi-flop synchronizer for an asynchronous active-low bus input;
// resets to the inactive (high) level.
module qbus_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/qbus_seq.sv
// Q-bus master transaction sequencer: turns a req/done port into
// address/data/IAK strobe sequences with nRPLY handshake and timeout.
module qbus_seq
  import qbus_pkg::*;
#(
  parameter int T_SET   = 2,
  parameter int T_TOUT  = 255,
  parameter int SYNC_FF = 2
) (
  input  logic        PIN_CLK,
  input  logic        PIN_RST,
  input  logic        req,
  input  logic [1:0]  cmd,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        irq,
  qbus_seq_if.master  bus
);

  localparam int TMW = $clog2(T_SET + 1);
  localparam int TOW = $clog2(T_TOUT + 1);
  localparam logic [TMW-1:0] TMR_LOAD  = TMW'(T_SET - 1);
  localparam logic [TOW-1:0] TOUT_LAST = TOW'(T_TOUT - 1);

  logic [3:0]     state, stateNxt;
  qbCmdT          cmdQ, cmdNxt;
  logic [15:0]    addrQ, addrNxt, wdataQ, wdataNxt, rdHold;
  logic [TMW-1:0] tmr;
  logic [TOW-1:0] tout;
  logic           errQ, rplyN, virqN, rply;
  logic           accept, toWr, toWn, finish;
  busOutT         busOut;

  qbus_sync #(.STAGES(SYNC_FF)) uSyncRply (
    .clk(PIN_CLK), .rst(PIN_RST), .d(bus.PIN_nRPLY), .q(rplyN));
  qbus_sync #(.STAGES(SYNC_FF)) uSyncVirq (
    .clk(PIN_CLK), .rst(PIN_RST), .d(bus.PIN_nVIRQ), .q(virqN));

  assign rply = ~rplyN;
  assign irq  = ~virqN;

  assign accept   = (state == ST_IDLE) && req;
  assign cmdNxt   = accept ? qbCmdT'(cmd) : cmdQ;
  assign addrNxt  = accept ? addr : addrQ;
  assign wdataNxt = accept ? wdata : wdataQ;
  assign toWr     = (state == ST_WRPLY) && !rply && (tout == TOUT_LAST);
  assign toWn     = (state == ST_WNRPLY) && rply && (tout == TOUT_LAST);
  assign finish   = (state == ST_WNRPLY) && (!rply || (tout == TOUT_LAST));

  // Pin levels for a given state; registered from the next state so the pads
  // change cleanly on the clock edge that enters each phase.
  function automatic busOutT decode(logic [3:0] st, qbCmdT c,
                                    logic [15:0] a, logic [15:0] w);
    busOutT o;
    o = BUS_IDLE;
    case (st)
      ST_ADDR, ST_ASYNC: begin
        o.oe    = 1'b1;
        o.nAd   = ~a;
        o.nWtbt = ~isWrite(c);
        o.nSync = (st == ST_ADDR);
      end
      ST_DATA, ST_STRB, ST_WRPLY, ST_SAMPLE: begin
        o.nSync = (c == QB_IAK);
        if (isWrite(c)) begin
          o.oe    = 1'b1;
          o.nAd   = ~w;
          o.nWtbt = (c != QB_WRB);
        end
        if (st != ST_DATA) begin
          o.nDin  = isWrite(c);
          o.nDout = ~isWrite(c);
          o.nIako = (c != QB_IAK);
        end
      end
      ST_NEG, ST_WNRPLY: begin
        if (isWrite(c)) begin
          o.oe  = 1'b1;
          o.nAd = ~w;
        end
      end
      default: o = BUS_IDLE;
    endcase
    return o;
  endfunction

  always_comb begin
    stateNxt = state;
    case (state)
      ST_IDLE:   if (req) stateNxt = (qbCmdT'(cmd) == QB_IAK) ? ST_DATA : ST_ADDR;
      ST_ADDR:   if (tmr == '0) stateNxt = ST_ASYNC;
      ST_ASYNC:  if (tmr == '0) stateNxt = ST_DATA;
      ST_DATA:   if (tmr == '0) stateNxt = ST_STRB;
      ST_STRB:   stateNxt = ST_WRPLY;
      ST_WRPLY:  if (rply) stateNxt = ST_SAMPLE;
                 else if (tout == TOUT_LAST) stateNxt = ST_NEG;
      ST_SAMPLE: if (tmr == '0) stateNxt = ST_NEG;
      ST_NEG:    stateNxt = ST_WNRPLY;
      ST_WNRPLY: if (finish) stateNxt = ST_IDLE;
      default:   stateNxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge PIN_CLK or posedge PIN_RST) begin
    if (PIN_RST) begin
      state  <= ST_IDLE;
      busOut <= BUS_IDLE;
      cmdQ   <= QB_RD;
      addrQ  <= '0;
      wdataQ <= '0;
      rdHold <= '0;
      rdata  <= '0;
      tmr    <= '0;
      tout   <= '0;
      errQ   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= stateNxt;
      busOut <= decode(stateNxt, cmdNxt, addrNxt, wdataNxt);
      if (accept) begin
        cmdQ   <= cmdNxt;
        addrQ  <= addr;
        wdataQ <= wdata;
        busy   <= 1'b1;
        errQ   <= 1'b0;
      end
      if ((stateNxt != state) &&
          (stateNxt inside {ST_ADDR, ST_ASYNC, ST_DATA, ST_SAMPLE}))
        tmr <= TMR_LOAD;
      else if (tmr != '0)
        tmr <= tmr - 1'b1;
      if ((state == ST_STRB) || (state == ST_NEG))
        tout <= '0;
      else if ((state == ST_WRPLY) || (state == ST_WNRPLY))
        tout <= tout + 1'b1;
      if (toWr) errQ <= 1'b1;
      if ((state == ST_SAMPLE) && (tmr == '0) && !isWrite(cmdQ))
        rdHold <= ~bus.PIN_nAD_in;
      // Read data only reaches rdata once the whole handshake closed cleanly.
      done <= finish;
      err  <= finish && (errQ || toWn);
      if (finish) begin
        busy <= 1'b0;
        if (!isWrite(cmdQ) && !(errQ || toWn)) rdata <= rdHold;
      end
    end
  end

  assign bus.PIN_nSYNC   = busOut.nSync;
  assign bus.PIN_nDIN    = busOut.nDin;
  assign bus.PIN_nDOUT   = busOut.nDout;
  assign bus.PIN_nWTBT   = busOut.nWtbt;
  assign bus.PIN_nIAKO   = busOut.nIako;
  assign bus.PIN_nAD_oe  = busOut.oe;
  assign bus.PIN_nAD_out = busOut.nAd;

endmodule

// File: tb/tb_qbus_seq.sv
// Directed bench for qbus_seq against a small vp_033 register/interrupt model.
module tb_qbus_seq;
  import qbus_pkg::*;

  localparam logic [15:0] CSR_A = 16'o167770;
  localparam logic [15:0] DAT_A = 16'o167772;
  localparam logic [15:0] VEC   = 16'o000170;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        busy, done, err, irq;

  qbus_seq_if bus();

  qbus_seq #(.T_SET(2), .T_TOUT(255), .SYNC_FF(2)) dut (
    .PIN_CLK(clk), .PIN_RST(rst), .req(req), .cmd(cmd), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .irq(irq), .bus(bus));

  always #5 clk = ~clk;

  // vp_033 model: CSR (bit 0 write-only), data register with byte lanes, IAK vector.
  logic [15:0] devAddr = '0, devCsr = '0, devData = '0, rdVal;
  logic        irqPend = 1'b0, irqKick = 1'b0, stuck = 1'b0, mapped, isCsr;

  assign isCsr  = (devAddr & 16'hFFFE) == CSR_A;
  assign mapped = isCsr || ((devAddr & 16'hFFFE) == DAT_A);
  assign rdVal  = isCsr ? (devCsr & 16'o177776) : devData;
  assign bus.PIN_nVIRQ = ~irqPend;
  assign bus.PIN_nRPLY = ~(stuck ||
                           (!bus.PIN_nDIN && !bus.PIN_nIAKO && irqPend) ||
                           (bus.PIN_nIAKO && mapped && (!bus.PIN_nDIN || !bus.PIN_nDOUT)));
  assign bus.PIN_nAD_in = (!bus.PIN_nIAKO && !bus.PIN_nDIN) ? ~VEC :
                          (!bus.PIN_nDIN && mapped) ? ~rdVal : 16'hFFFF;

  always @(negedge bus.PIN_nSYNC) devAddr <= ~bus.PIN_nAD_out;

  always @(negedge bus.PIN_nDOUT) begin
    if (isCsr) devCsr <= ~bus.PIN_nAD_out;
    else if (mapped) begin
      if (bus.PIN_nWTBT)   devData <= ~bus.PIN_nAD_out;
      else if (devAddr[0]) devData[15:8] <= ~bus.PIN_nAD_out[15:8];
      else                 devData[7:0]  <= ~bus.PIN_nAD_out[7:0];
    end
  end

  always @(posedge bus.PIN_nIAKO or posedge irqKick) irqPend <= irqKick;

  // Per-transaction pin monitor; rc counts cycles from the accept edge.
  int          rc = 0, tAddr = -1, tSync = -1, tStrbOn = -1, tStrbOff = -1;
  logic        busyPrev = 1'b0, syncSeenLow = 1'b0, iakoDin = 1'b0;
  logic        rplySeen = 1'b0, rplyBeforeNeg = 1'b0, wtbtAddr = 1'b1, wtbtData = 1'b1;
  logic [15:0] dataOut = '0;

  always @(negedge clk) begin
    if (busy && !busyPrev) begin
      rc = 0; tAddr = -1; tSync = -1; tStrbOn = -1; tStrbOff = -1;
      syncSeenLow = 1'b0; iakoDin = 1'b0; rplySeen = 1'b0; rplyBeforeNeg = 1'b0;
      wtbtAddr = 1'b1; wtbtData = 1'b1; dataOut = '0;
    end else begin
      rc++;
    end
    busyPrev = busy;
    if (busy) begin
      if (bus.PIN_nAD_oe && bus.PIN_nSYNC && bus.PIN_nDIN && bus.PIN_nDOUT && tAddr < 0) begin
        tAddr = rc;
        wtbtAddr = bus.PIN_nWTBT;
      end
      if (!bus.PIN_nSYNC) begin
        syncSeenLow = 1'b1;
        if (tSync < 0) tSync = rc;
      end
      if (!bus.PIN_nDOUT) begin
        wtbtData = bus.PIN_nWTBT;
        dataOut = ~bus.PIN_nAD_out;
      end
      if (!bus.PIN_nDIN || !bus.PIN_nDOUT) begin
        if (tStrbOn < 0) tStrbOn = rc;
        if (!bus.PIN_nRPLY) rplySeen = 1'b1;
        if (!bus.PIN_nIAKO && !bus.PIN_nDIN) iakoDin = 1'b1;
      end else if (tStrbOn >= 0 && tStrbOff < 0) begin
        tStrbOff = rc;
        rplyBeforeNeg = rplySeen;
      end
    end
  end

  int nVec = 0, nMis = 0;

  task automatic checkVec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic doTxn(input logic [1:0] c, input logic [15:0] a, input logic [15:0] w,
                       output int lat, output logic e, output logic [15:0] rd);
    @(negedge clk);
    req = 1'b1; cmd = c; addr = a; wdata = w;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!done && lat < 2000);
    e  = err;
    rd = rdata;
    checkVec("done seen", 32'(done), 32'd1);
  endtask

  int          lat, n;
  logic        e;
  logic [15:0] rd;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkVec("reset strobes/oe",
             32'({bus.PIN_nSYNC, bus.PIN_nDIN, bus.PIN_nDOUT, bus.PIN_nWTBT, bus.PIN_nIAKO, bus.PIN_nAD_oe}),
             32'b111110);
    checkVec("reset nAD_out", 32'(bus.PIN_nAD_out), 32'hFFFF);
    checkVec("reset rdata", 32'(rdata), 32'd0);
    checkVec("reset busy/done/err/irq", 32'({busy, done, err, irq}), 32'd0);

    // Reset while a write sits in its DOUT strobe.
    @(negedge clk);
    req = 1'b1; cmd = QB_WR; addr = CSR_A; wdata = 16'h1111;
    @(posedge clk);
    #1 req = 1'b0;
    n = 0;
    while (bus.PIN_nDOUT && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    checkVec("rst: reached DOUT", 32'(bus.PIN_nDOUT), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkVec("rst: strobes/oe released",
             32'({bus.PIN_nSYNC, bus.PIN_nDIN, bus.PIN_nDOUT, bus.PIN_nWTBT, bus.PIN_nIAKO, bus.PIN_nAD_oe}),
             32'b111110);
    checkVec("rst: busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Word write 167770 <- 040000.
    doTxn(QB_WR, CSR_A, 16'o040000, lat, e, rd);
    checkVec("wr: err", 32'(e), 32'd0);
    checkVec("wr: addr->SYNC cycles", 32'(tSync - tAddr), 32'd2);
    checkVec("wr: nWTBT in addr", 32'(wtbtAddr), 32'd0);
    checkVec("wr: nWTBT in data", 32'(wtbtData), 32'd1);
    checkVec("wr: device CSR", 32'(devCsr), 32'(16'o040000));

    // CSR read-back after writing 000101: bit 0 is write-only.
    doTxn(QB_WR, CSR_A, 16'o000101, lat, e, rd);
    doTxn(QB_RD, CSR_A, 16'h0000, lat, e, rd);
    checkVec("rd: rdata", 32'(rd), 32'(16'o000100));
    checkVec("rd: err", 32'(e), 32'd0);
    checkVec("rd: RPLY before negate", 32'(rplyBeforeNeg), 32'd1);
    // nominal 4*T_SET + 2*SYNC_FF + 3 = 15 cycles, +/-1 allowed
    checkVec("rd: latency", 32'((lat >= 14 && lat <= 16) ? 15 : lat), 32'd15);
    @(posedge clk);
    #1 checkVec("rd: done one cycle", 32'(done), 32'd0);

    // Byte writes to both lanes of the data register, full word on the bus.
    doTxn(QB_WRB, DAT_A, 16'o000165, lat, e, rd);
    checkVec("wrb: err", 32'(e), 32'd0);
    checkVec("wrb: nWTBT in DOUT", 32'(wtbtData), 32'd0);
    doTxn(QB_WRB, DAT_A | 16'h0001, 16'h1234, lat, e, rd);
    checkVec("wrb odd: full word driven", 32'(dataOut), 32'h1234);
    doTxn(QB_RD, DAT_A, 16'h0000, lat, e, rd);
    checkVec("wrb: data reg readback", 32'(rd), 32'h1275);

    // Interrupt request, then acknowledge.
    @(negedge clk) irqKick = 1'b1;
    @(posedge clk);
    #1 checkVec("irq after 1 cycle", 32'(irq), 32'd0);
    @(posedge clk);
    #1 checkVec("irq after SYNC_FF cycles", 32'(irq), 32'd1);
    irqKick = 1'b0;
    doTxn(QB_IAK, 16'h0000, 16'h0000, lat, e, rd);
    checkVec("iak: vector", 32'(rd), 32'(VEC));
    checkVec("iak: err", 32'(e), 32'd0);
    checkVec("iak: nSYNC stayed high", 32'(syncSeenLow), 32'd0);
    checkVec("iak: nIAKO with nDIN", 32'(iakoDin), 32'd1);
    repeat (4) @(posedge clk);
    #1 checkVec("iak: irq dropped", 32'(irq), 32'd0);

    // Unmapped read: one STRB cycle plus T_TOUT WRPLY cycles, then release.
    doTxn(QB_RD, 16'o160000, 16'h0000, lat, e, rd);
    checkVec("tout: err", 32'(e), 32'd1);
    checkVec("tout: rdata unchanged", 32'(rd), 32'(VEC));
    checkVec("tout: strobe low cycles", 32'(tStrbOff - tStrbOn), 32'd256);
    checkVec("tout: strobes released", 32'({bus.PIN_nSYNC, bus.PIN_nDIN}), 32'b11);

    // nRPLY stuck low: counts as reply, then the negate wait times out.
    @(negedge clk) stuck = 1'b1;
    repeat (4) @(negedge clk);
    doTxn(QB_RD, CSR_A, 16'h0000, lat, e, rd);
    checkVec("stuck: err", 32'(e), 32'd1);
    checkVec("stuck: rdata unchanged", 32'(rd), 32'(VEC));
    stuck = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/qbus_seq.md
Name: qbus_seq

Overview:
- Synthesizable Q-bus master transaction sequencer that drives the 1801VP1-033 (vp_033) bus interface from a simple request/done port.
- Generates the address, data and interrupt-acknowledge strobe sequences on nSYNC/nDIN/nDOUT/nWTBT/nIAKO and handshakes on nRPLY, with a timeout.
- Sits between an on-chip controller (CPU core or test sequencer) and the vp_033 Q-bus pins, so the 033 PIO/FDC path can be exercised in hardware without a processor.

Parameters:
- T_SET, 2, setup/deskew cycles between phase changes (address→SYNC, SYNC→data, data→strobe, RPLY→sample)
- T_TOUT, 255, max cycles waiting for an nRPLY edge before bus error
- SYNC_FF, 2, nRPLY/nVIRQ synchronizer depth (2..3)

Ports:
- PIN_CLK  in  1  system clock
- PIN_RST  in  1  asynchronous reset, active-high
- req  in  1  start transaction; sampled only in IDLE
- cmd  in  2  00 read word, 01 write word, 10 write byte, 11 interrupt acknowledge
- addr  in  16  bus address; addr[0] selects byte lane for cmd 10
- wdata  in  16  write data
- rdata  out  16  read data / vector, valid with done
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at end of transaction
- err  out  1  valid with done: RPLY timeout
- irq  out  1  synchronized, inverted nVIRQ
- PIN_nAD_out  out  16  inverted address/data to bus
- PIN_nAD_oe  out  1  AD drive enable, active-high
- PIN_nAD_in  in  16  bus AD sampled (active-low)
- PIN_nSYNC, PIN_nDIN, PIN_nDOUT, PIN_nWTBT, PIN_nIAKO  out  1 each  bus strobes, active-low
- PIN_nRPLY, PIN_nVIRQ  in  1 each  active-low, asynchronous

Behaviour:
- Reset (async): state IDLE; all active-low strobes 1; PIN_nAD_oe 0; PIN_nAD_out 16'hFFFF; rdata 0; busy/done/err 0; timers 0.
- nRPLY and nVIRQ pass through SYNC_FF flops before use; rply = ~synced nRPLY.
- Single phase timer counts T_SET; a separate timeout counter is used in the RPLY waits.
- States: IDLE → ADDR → ASYNC → DATA → STRB → WRPLY → SAMPLE → NEG → WNRPLY → IDLE.
- IDLE: req=1 latches cmd/addr/wdata, busy=1. cmd 11 goes directly to DATA.
- ADDR: drive ~addr, oe=1; nWTBT=0 for cmd 01/10; hold T_SET cycles.
- ASYNC: nSYNC=0, address held T_SET cycles.
- DATA (read/IAK): oe=0, nWTBT=1. DATA (write): drive ~wdata; nWTBT=0 only for cmd 10. Hold T_SET cycles.
- STRB: read → nDIN=0; write → nDOUT=0; IAK → nDIN=0 and nIAKO=0, nSYNC stays 1. Clear timeout counter.
- WRPLY: wait for rply=1. If the counter reaches T_TOUT, set err=1 and go to NEG.
- SAMPLE: wait T_SET cycles, then rdata = ~PIN_nAD_in for read/IAK. Write holds rdata unchanged.
- NEG: nSYNC, nDIN, nDOUT and nIAKO all return to 1 in the same cycle. Clear timeout counter.
- WNRPLY: wait for rply=0. Write keeps oe=1 until rply=0 or timeout, then drops oe. On timeout set err. Then pulse done, busy=0, go to IDLE.
- On error, rdata is unchanged.
- Latency (read, T_SET=2, device replies immediately): done occurs 4·T_SET + SYNC_FF·2 + 3 cycles after accept, ±1 cycle.
- req while busy is ignored; there is no queueing.
- Reset mid-transaction releases all strobes and AD in the same instant.
- nRPLY already low at STRB (stuck bus): that cycle counts as the reply. WNRPLY then times out, producing err=1.
- cmd 10 with any addr[0] drives the full word; the byte lane is chosen by the device from the address.

Decomposition:
- Package qbus_pkg: cmd encodings (QB_RD, QB_WR, QB_WRB, QB_IAK) and the state enum.
- Sub-module qbus_sync (SYNC_FF-deep async input synchronizer) is instantiated for nRPLY and nVIRQ.
- Everything else stays in one FSM module.

Test Plan:
- Reset asserted mid-STRB of a write → all strobes 1 and oe=0 within the reset delta; busy=0; next req accepted normally.
- Write 167770←040000 to vp_033 model → nSYNC falls T_SET cycles after the address is driven; nWTBT=0 in the address phase and 1 in data; done with err=0.
- Read 167770 after writing 000101 → rdata bit 6 = 1 and bit 0 = 0 within the polling loop; strobes negate only after nRPLY is low.
- Write byte 167772←000165 → nWTBT=0 during DOUT; done err=0.
- Device interrupt → irq=1 after SYNC_FF cycles; IAK command → nSYNC stays 1, nIAKO=0 with nDIN=0; rdata equals the 033 vector; irq drops after acknowledge.
- Read unmapped address 160000 (no responder) → err=1 exactly T_TOUT cycles after STRB; strobes released; rdata unchanged.
